kb_event_rx: RTL and testbench

- Parametrised PS/2 keyboard front-end: receives 11-bit PS/2 frames, decodes Set-2 prefixes (E0, F0, E1), and emits one event word per key action: make/break flag, extended flag, 8-bit code.
- Events are buffered in a configurable first-word-fall-through FIFO for the CPU's keyboard I/O port.
- Adds over the previous keyboard block:
  - break events carrying key identity;
  - extended-key tagging;
  - pause-sequence collapse;
  - parity/framing checks with frame timeout;
  - overflow reporting.

---
 rtl/kb_pkg.sv | 38 +++
 rtl/ps2_frame_rx.sv | 130 +++++++++++++
 rtl/kb_event_rx.sv | 187 ++++++++++++++++++
 tb/tb_kb_event_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kb_pkg.sv
// Shared definitions for the PS/2 keyboard event receiver: event word layout,
// Set-2 prefix bytes, decoder states and the list of bytes that carry no key.
package kb_pkg;

  localparam int BRK      = 9;
  localparam int EXT      = 8;
  localparam int CODE_MSB = 7;
  localparam int CODE_LSB = 0;

  localparam logic [7:0] PFX_E0     = 8'hE0;
  localparam logic [7:0] PFX_F0     = 8'hF0;
  localparam logic [7:0] PFX_E1     = 8'hE1;
  localparam logic [7:0] FAKE_SHIFT = 8'h12;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef logic [9:0] kb_event_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0,
    S_PAUSE
  } dec_state_e;

  // Keyboard status/response bytes that never describe a key.
  function automatic logic is_dropped(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    case (b)
      8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFE: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises and filters the line clock, shifts in
// 11-bit frames, checks odd parity and stop bit, and aborts stalled frames.
module ps2_frame_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2d_i,
  input  logic       ps2c_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic       abort_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    csync_q, dsync_q;
  logic          fclk_q, fprev_q;
  logic [FW-1:0] fcnt_q;
  logic          fall;
  logic          ds;

  logic          busy_q, busy_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [8:0]    sh_q, sh_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          bvalid_q, bvalid_d;
  logic          ferr_q, ferr_d;
  logic          abort_q, abort_d;

  // Lines idle high, so synchronisers and filter start high to avoid a bogus edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csync_q <= 2'b11;
      dsync_q <= 2'b11;
      fclk_q  <= 1'b1;
      fprev_q <= 1'b1;
      fcnt_q  <= '0;
    end else begin
      csync_q <= {csync_q[0], ps2c_i};
      dsync_q <= {dsync_q[0], ps2d_i};
      fprev_q <= fclk_q;
      if (csync_q[1] == fclk_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        fclk_q <= csync_q[1];
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + FW'(1);
      end
    end
  end

  assign fall = fprev_q & ~fclk_q;
  assign ds   = dsync_q[1];

  always_comb begin
    busy_d   = busy_q;
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    tcnt_d   = tcnt_q;
    byte_d   = byte_q;
    bvalid_d = 1'b0;
    ferr_d   = 1'b0;
    abort_d  = 1'b0;
    if (fall) begin
      tcnt_d = '0;
      if (!busy_q) begin
        if (!ds) begin
          busy_d   = 1'b1;
          bitcnt_d = 4'd1;
        end
      end else if (bitcnt_q == 4'd10) begin
        busy_d   = 1'b0;
        bitcnt_d = '0;
        // Data plus parity must hold an odd number of ones.
        if (ds && (^sh_q)) begin
          byte_d   = sh_q[7:0];
          bvalid_d = 1'b1;
        end else begin
          ferr_d = 1'b1;
        end
      end else begin
        sh_d     = {ds, sh_q[8:1]};
        bitcnt_d = bitcnt_q + 4'd1;
      end
    end else if (busy_q) begin
      if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
        busy_d   = 1'b0;
        bitcnt_d = '0;
        tcnt_d   = '0;
        abort_d  = 1'b1;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      bitcnt_q <= '0;
      sh_q     <= '0;
      tcnt_q   <= '0;
      byte_q   <= '0;
      bvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      bitcnt_q <= bitcnt_d;
      sh_q     <= sh_d;
      tcnt_q   <= tcnt_d;
      byte_q   <= byte_d;
      bvalid_q <= bvalid_d;
      ferr_q   <= ferr_d;
      abort_q  <= abort_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = bvalid_q;
  assign frame_err_o  = ferr_q;
  assign abort_o      = abort_q;

endmodule

// File: rtl/kb_event_rx.sv
// PS/2 keyboard front-end: Set-2 prefix decoder turning received bytes into
// {brk, ext, code} events, buffered in a first-word-fall-through FIFO.
module kb_event_rx
  import kb_pkg::*;
#(
  parameter int FIFO_AW     = 4,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int DROP_BREAK  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2d,
  input  logic             ps2c,
  input  logic             rd_en,
  input  logic             clr_err,
  output logic [9:0]       rd_data,
  output logic             empty,
  output logic             full,
  output logic [FIFO_AW:0] count,
  output logic             ev_valid,
  output logic [9:0]       ev_data,
  output logic [8:0]       last_make,
  output logic             frame_err,
  output logic             overflow
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr, rx_abort;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .ps2d_i      (ps2d),
    .ps2c_i      (ps2c),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_ferr),
    .abort_o     (rx_abort)
  );

  dec_state_e state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic       ev_valid_q, ev_valid_d;
  kb_event_t  ev_data_q, ev_data_d;
  logic [8:0] last_make_q, last_make_d;
  logic       emit;
  kb_event_t  word;

  // A bad or abandoned frame leaves any prefix sequence meaningless.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    word    = '0;
    if (rx_ferr || rx_abort) begin
      state_d = S_IDLE;
    end else if (rx_valid) begin
      word[CODE_MSB:CODE_LSB] = rx_byte;
      case (state_q)
        S_IDLE: begin
          if (rx_byte == PFX_E0) begin
            state_d = S_E0;
          end else if (rx_byte == PFX_F0) begin
            state_d = S_F0;
          end else if (rx_byte == PFX_E1) begin
            state_d = S_PAUSE;
            skip_d  = PAUSE_SKIP;
          end else if (!is_dropped(rx_byte)) begin
            emit = 1'b1;
          end
        end
        S_E0: begin
          if (rx_byte == PFX_F0) begin
            state_d = S_E0F0;
          end else begin
            state_d   = S_IDLE;
            word[EXT] = 1'b1;
            emit      = (rx_byte != FAKE_SHIFT);
          end
        end
        S_F0: begin
          state_d   = S_IDLE;
          word[BRK] = 1'b1;
          emit      = 1'b1;
        end
        S_E0F0: begin
          state_d   = S_IDLE;
          word[BRK] = 1'b1;
          word[EXT] = 1'b1;
          emit      = (rx_byte != FAKE_SHIFT);
        end
        S_PAUSE: begin
          // The whole pause sequence reports as a single extended E1 make.
          if (skip_q == 3'd1) begin
            state_d                 = S_IDLE;
            word[CODE_MSB:CODE_LSB] = PFX_E1;
            word[EXT]               = 1'b1;
            emit                    = 1'b1;
          end
          skip_d = skip_q - 3'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
    ev_valid_d  = emit;
    ev_data_d   = emit ? word : ev_data_q;
    last_make_d = (emit && !word[BRK]) ? word[8:0] : last_make_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      skip_q      <= '0;
      ev_valid_q  <= 1'b0;
      ev_data_q   <= '0;
      last_make_q <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      ev_valid_q  <= ev_valid_d;
      ev_data_q   <= ev_data_d;
      last_make_q <= last_make_d;
    end
  end

  kb_event_t          mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               overflow_q;
  logic               full_w, empty_w, keep, do_wr, do_pop, lost;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);
  assign keep    = !(ev_data_q[BRK] && (DROP_BREAK != 0));
  assign do_pop  = rd_en && !empty_w;
  assign do_wr   = ev_valid_q && keep && (!full_w || rd_en);
  assign lost    = ev_valid_q && keep && full_w && !rd_en;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= ev_data_q;
    end
  end

  // Lost events win over a coincident clear so none goes unreported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_wr, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (lost) begin
        overflow_q <= 1'b1;
      end else if (clr_err) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign rd_data   = empty_w ? '0 : mem_q[rd_ptr_q];
  assign empty     = empty_w;
  assign full      = full_w;
  assign count     = count_q;
  assign ev_valid  = ev_valid_q;
  assign ev_data   = ev_data_q;
  assign last_make = last_make_q;
  assign frame_err = rx_ferr;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_kb_event_rx.sv
// Directed bench for kb_event_rx: PS/2 frames in, events scored against an
// expected-event queue and a FIFO model queue.
module tb_kb_event_rx;

  localparam int FIFO_AW = 4;
  localparam int DEPTH   = 16;
  localparam int TO_CYC  = 500;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ps2d = 1'b1;
  logic             ps2c = 1'b1;
  logic             rd_en = 1'b0;
  logic             clr_err = 1'b0;
  logic [9:0]       rd_data;
  logic             empty, full;
  logic [FIFO_AW:0] count;
  logic             ev_valid;
  logic [9:0]       ev_data;
  logic [8:0]       last_make;
  logic             frame_err, overflow;

  int testCount = 0;
  int failCount = 0;
  int errPulses = 0;
  logic [9:0] expQ[$];
  logic [9:0] fifoQ[$];
  logic [9:0] expEv;

  kb_event_rx #(
    .FIFO_AW    (FIFO_AW),
    .FILTER_LEN (8),
    .TIMEOUT_CYC(TO_CYC),
    .DROP_BREAK (0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2d     (ps2d),
    .ps2c     (ps2c),
    .rd_en    (rd_en),
    .clr_err  (clr_err),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .ev_valid (ev_valid),
    .ev_data  (ev_data),
    .last_make(last_make),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expectEvent(input logic [9:0] ev);
    expQ.push_back(ev);
    if (fifoQ.size() < DEPTH) fifoQ.push_back(ev);
  endtask

  task automatic sendBit(input logic b);
    ps2d = b;
    repeat (10) @(posedge clk);
    ps2c = 1'b0;
    repeat (20) @(posedge clk);
    ps2c = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  // One complete frame; badParity flips the parity bit.
  task automatic applyStimulus(input logic [7:0] b, input logic badParity);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit((~^b) ^ badParity);
    sendBit(1'b1);
    ps2d = 1'b1;
    repeat (30) @(posedge clk);
  endtask

  task automatic popCheck(input string tag);
    @(negedge clk);
    expEv = fifoQ.pop_front();
    checkOutput(tag, rd_data, expEv);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // Scoreboard: every ev_valid pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && frame_err) errPulses++;
    if (!rst && ev_valid) begin
      testCount++;
      assert (expQ.size() != 0) else begin
        failCount++;
        $error("[TB] FAIL unexpected_event observed=%h expected=none", ev_data);
      end
      if (expQ.size() != 0) begin
        checkOutput("ev_data", ev_data, expQ.pop_front());
      end
    end
  end

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_last_make", last_make, 0);
    checkOutput("rst_overflow", overflow, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("idle_ev_data", ev_data, 0);
    checkOutput("idle_full", full, 0);

    expectEvent(10'h01C);
    applyStimulus(8'h1C, 1'b0);
    checkOutput("make_pending", expQ.size(), 0);
    checkOutput("make_rd_data", rd_data, 10'h01C);
    checkOutput("make_count", count, 1);
    checkOutput("make_last_make", last_make, 9'h01C);

    applyStimulus(8'hF0, 1'b0);
    expectEvent(10'h21C);
    applyStimulus(8'h1C, 1'b0);
    checkOutput("brk_pending", expQ.size(), 0);
    checkOutput("brk_last_make", last_make, 9'h01C);
    checkOutput("brk_count", count, 2);

    applyStimulus(8'hE0, 1'b0);
    expectEvent(10'h175);
    applyStimulus(8'h75, 1'b0);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    expectEvent(10'h375);
    applyStimulus(8'h75, 1'b0);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h12, 1'b0);
    applyStimulus(8'hAA, 1'b0);
    checkOutput("ext_pending", expQ.size(), 0);
    checkOutput("ext_last_make", last_make, 9'h175);
    checkOutput("ext_count", count, 4);

    applyStimulus(8'h1C, 1'b1);
    checkOutput("parity_err_pulses", errPulses, 1);
    checkOutput("parity_count", count, 4);
    applyStimulus(8'hF0, 1'b0);
    expectEvent(10'h21C);
    applyStimulus(8'h1C, 1'b0);
    checkOutput("recover_pending", expQ.size(), 0);

    applyStimulus(8'hE1, 1'b0);
    applyStimulus(8'h14, 1'b0);
    applyStimulus(8'h77, 1'b0);
    applyStimulus(8'hE1, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h14, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    expectEvent(10'h1E1);
    applyStimulus(8'h77, 1'b0);
    checkOutput("pause_pending", expQ.size(), 0);
    checkOutput("pause_last_make", last_make, 9'h1E1);

    // A stalled frame after E0 must clear the prefix.
    applyStimulus(8'hE0, 1'b0);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    ps2d = 1'b1;
    repeat (TO_CYC + 100) @(posedge clk);
    expectEvent(10'h01C);
    applyStimulus(8'h1C, 1'b0);
    checkOutput("timeout_pending", expQ.size(), 0);
    checkOutput("timeout_err_pulses", errPulses, 1);
    checkOutput("timeout_count", count, 7);

    while (fifoQ.size() != 0) popCheck("drain_rd_data");
    @(negedge clk);
    checkOutput("drain_empty", empty, 1);
    checkOutput("drain_rd_data_zero", rd_data, 0);

    for (int i = 0; i < 17; i++) begin
      expectEvent(10'h020 + 10'(i));
      applyStimulus(8'h20 + 8'(i), 1'b0);
    end
    checkOutput("full_pending", expQ.size(), 0);
    checkOutput("full_count", count, 16);
    checkOutput("full_flag", full, 1);
    checkOutput("full_overflow", overflow, 1);
    checkOutput("full_head", rd_data, 10'h020);

    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checkOutput("clr_overflow", overflow, 0);

    expQ.push_back(10'h040);
    fork
      applyStimulus(8'h40, 1'b0);
      begin : popWatch
        int c;
        c = 0;
        @(negedge clk);
        while (!ev_valid && c < 3000) begin
          @(negedge clk);
          c++;
        end
        checkOutput("popwr_seen", ev_valid, 1);
        if (ev_valid) begin
          expEv = fifoQ.pop_front();
          checkOutput("popwr_head", rd_data, expEv);
          fifoQ.push_back(10'h040);
          rd_en = 1'b1;
          @(negedge clk);
          rd_en = 1'b0;
        end
      end
    join
    checkOutput("popwr_count", count, 16);
    checkOutput("popwr_full", full, 1);
    checkOutput("popwr_overflow", overflow, 0);
    checkOutput("popwr_new_head", rd_data, 10'h021);

    while (fifoQ.size() != 0) popCheck("final_rd_data");
    @(negedge clk);
    checkOutput("final_empty", empty, 1);
    checkOutput("final_count", count, 0);
    checkOutput("final_pending", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
